// File: rtl/change_dispenser.sv
// Change dispenser: captures the owed amount on a Deliver rising edge and pays it out
// greedily (50/10/5c) through a 4-phase request/acknowledge handshake with the coin ejector.
module change_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic       Deliver,
    input  logic [7:0] Money,
    input  logic       Empty50,
    input  logic       Empty10,
    input  logic       Empty5,
    input  logic       EjectAck,
    output logic       EjectReq,
    output logic [1:0] CoinSel,
    output logic       Busy,
    output logic       Done,
    output logic       Fault,
    output logic [7:0] Remain,
    output logic [5:0] CoinCount
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        EJECT   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_5    = 2'b01;
    localparam logic [1:0] SEL_10   = 2'b10;
    localparam logic [1:0] SEL_50   = 2'b11;

    // The timer counts from 0, so the last allowed count is one below the limit.
    localparam logic [9:0] TIMEOUT_LAST = 10'(ACK_TIMEOUT - 1);

    state_t     state_r;
    logic       deliver_r;
    logic [9:0] timer_r;
    logic [1:0] pick_sel_s;
    logic       pick_valid_s;
    logic       capture_s;
    logic       timer_last_s;

    function automatic logic [7:0] coin_value(input logic [1:0] sel);
        logic [7:0] val;
        case (sel)
            SEL_5:   val = 8'd5;
            SEL_10:  val = 8'd10;
            SEL_50:  val = 8'd50;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

    // Greedy coin choice: largest coin that fits the remainder and whose tube is not empty.
    always_comb begin
        pick_sel_s   = SEL_NONE;
        pick_valid_s = 1'b0;
        if ((Remain >= 8'd50) && !Empty50) begin
            pick_sel_s   = SEL_50;
            pick_valid_s = 1'b1;
        end else if ((Remain >= 8'd10) && !Empty10) begin
            pick_sel_s   = SEL_10;
            pick_valid_s = 1'b1;
        end else if ((Remain >= 8'd5) && !Empty5) begin
            pick_sel_s   = SEL_5;
            pick_valid_s = 1'b1;
        end else begin
            pick_sel_s   = SEL_NONE;
            pick_valid_s = 1'b0;
        end
    end

    // Capture qualification and handshake-phase timeout detection.
    always_comb begin
        capture_s    = Enable && Deliver && !deliver_r;
        timer_last_s = (timer_r == TIMEOUT_LAST);
    end

    // Main FSM with registered outputs; FAULT is only left through reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= IDLE;
            deliver_r <= 1'b0;
            timer_r   <= 10'd0;
            EjectReq  <= 1'b0;
            CoinSel   <= SEL_NONE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Fault     <= 1'b0;
            Remain    <= 8'd0;
            CoinCount <= 6'd0;
        end else begin
            deliver_r <= Deliver;
            case (state_r)
                IDLE: begin
                    Done <= 1'b0;
                    Busy <= 1'b0;
                    if (capture_s) begin
                        Remain    <= Money;
                        CoinCount <= 6'd0;
                        Busy      <= 1'b1;
                        state_r   <= SELECT;
                    end
                end
                SELECT: begin
                    if (Remain == 8'd0) begin
                        state_r <= DONE;
                    end else if (pick_valid_s) begin
                        CoinSel  <= pick_sel_s;
                        EjectReq <= 1'b1;
                        timer_r  <= 10'd0;
                        state_r  <= EJECT;
                    end else begin
                        Fault    <= 1'b1;
                        Busy     <= 1'b0;
                        EjectReq <= 1'b0;
                        CoinSel  <= SEL_NONE;
                        state_r  <= FAULT;
                    end
                end
                EJECT: begin
                    if (EjectAck) begin
                        Remain    <= Remain - coin_value(CoinSel);
                        CoinCount <= CoinCount + 6'd1;
                        EjectReq  <= 1'b0;
                        CoinSel   <= SEL_NONE;
                        timer_r   <= 10'd0;
                        state_r   <= RELEASE;
                    end else if (timer_last_s) begin
                        Fault    <= 1'b1;
                        Busy     <= 1'b0;
                        EjectReq <= 1'b0;
                        CoinSel  <= SEL_NONE;
                        state_r  <= FAULT;
                    end else begin
                        timer_r <= timer_r + 10'd1;
                    end
                end
                RELEASE: begin
                    if (!EjectAck) begin
                        state_r <= SELECT;
                    end else if (timer_last_s) begin
                        Fault    <= 1'b1;
                        Busy     <= 1'b0;
                        EjectReq <= 1'b0;
                        CoinSel  <= SEL_NONE;
                        state_r  <= FAULT;
                    end else begin
                        timer_r <= timer_r + 10'd1;
                    end
                end
                DONE: begin
                    // Busy stays high through the Done pulse and drops with it in IDLE.
                    Done    <= 1'b1;
                    state_r <= IDLE;
                end
                FAULT: begin
                    Fault    <= 1'b1;
                    Busy     <= 1'b0;
                    EjectReq <= 1'b0;
                    CoinSel  <= SEL_NONE;
                    state_r  <= FAULT;
                end
                default: begin
                    Fault    <= 1'b1;
                    Busy     <= 1'b0;
                    EjectReq <= 1'b0;
                    CoinSel  <= SEL_NONE;
                    state_r  <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coin/done/fault events are queued by the
// stimulus and consumed by a monitor; an ejector model answers the handshake.
module tb_change_dispenser;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Enable = 1'b1;
    logic       Deliver = 1'b0;
    logic [7:0] Money = 8'd0;
    logic       Empty50 = 1'b0;
    logic       Empty10 = 1'b0;
    logic       Empty5 = 1'b0;
    logic       EjectAck = 1'b0;
    logic       EjectReq;
    logic [1:0] CoinSel;
    logic       Busy;
    logic       Done;
    logic       Fault;
    logic [7:0] Remain;
    logic [5:0] CoinCount;

    change_dispenser #(.ACK_TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .Enable(Enable), .Deliver(Deliver), .Money(Money),
        .Empty50(Empty50), .Empty10(Empty10), .Empty5(Empty5), .EjectAck(EjectAck),
        .EjectReq(EjectReq), .CoinSel(CoinSel), .Busy(Busy), .Done(Done), .Fault(Fault),
        .Remain(Remain), .CoinCount(CoinCount)
    );

    always #5 CLK = ~CLK;

    localparam int K_COIN  = 0;
    localparam int K_DONE  = 1;
    localparam int K_FAULT = 2;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [5:0] b;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  ack_en = 1'b1;
    int  ack_delay = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] a, input logic [5:0] b);
        ev_t e;
        e.kind = k;
        e.a = a;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        logic prev_req;
        logic prev_fault;
        ev_t  e;
        prev_req = 1'b0;
        prev_fault = 1'b0;
        forever begin
            @(negedge CLK);
            if (EjectReq && !prev_req) begin
                chk("coin_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("coin_kind", e.kind, K_COIN);
                    chk("coin_sel", 32'(CoinSel), 32'(e.a));
                end
            end
            if (Done) begin
                chk("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("done_kind", e.kind, K_DONE);
                    chk("done_remain", 32'(Remain), 32'(e.a));
                    chk("done_count", 32'(CoinCount), 32'(e.b));
                    chk("done_busy", 32'(Busy), 32'd1);
                    chk("done_fault", 32'(Fault), 32'd0);
                end
            end
            if (Fault && !prev_fault) begin
                chk("fault_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("fault_kind", e.kind, K_FAULT);
                    chk("fault_remain", 32'(Remain), 32'(e.a));
                    chk("fault_count", 32'(CoinCount), 32'(e.b));
                    chk("fault_busy", 32'(Busy), 32'd0);
                end
            end
            prev_req = EjectReq;
            prev_fault = Fault;
        end
    endtask

    task automatic ejector();
        forever begin
            @(posedge CLK);
            #1;
            if (ack_en && EjectReq && !EjectAck) begin
                repeat (ack_delay) @(posedge CLK);
                #1;
                EjectAck = 1'b1;
                while (EjectReq) begin
                    @(posedge CLK);
                    #1;
                end
                EjectAck = 1'b0;
            end
        end
    endtask

    // Returns 1ns after the edge that samples the Deliver rising edge.
    task automatic deliver(input logic [7:0] m);
        @(posedge CLK);
        #1;
        Money = m;
        Deliver = 1'b1;
        @(posedge CLK);
        #1;
        Deliver = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge CLK);
        chk(name, 32'(exp_q.size()), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        int cnt;
        fork
            monitor();
            ejector();
        join_none

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 32'({EjectReq, CoinSel, Busy, Done, Fault, Remain, CoinCount}), 32'd0);
        RST = 1'b1;

        // 85c, all tubes full
        push(K_COIN, 8'd3, 6'd0);
        push(K_COIN, 8'd2, 6'd0);
        push(K_COIN, 8'd2, 6'd0);
        push(K_COIN, 8'd2, 6'd0);
        push(K_COIN, 8'd1, 6'd0);
        push(K_DONE, 8'd0, 6'd5);
        deliver(8'd85);
        chk("capture_remain", 32'(Remain), 32'd85);
        chk("capture_busy", 32'(Busy), 32'd1);
        chk("capture_noreq", 32'(EjectReq), 32'd0);
        @(posedge CLK);
        #1;
        chk("first_req", 32'(EjectReq), 32'd1);
        chk("first_sel", 32'(CoinSel), 32'd3);
        wait_drain("drain_85", 200);
        chk("idle_busy_85", 32'(Busy), 32'd0);
        chk("idle_count_85", 32'(CoinCount), 32'd5);

        // 60c with the 50c tube empty
        Empty50 = 1'b1;
        for (int i = 0; i < 6; i++) push(K_COIN, 8'd2, 6'd0);
        push(K_DONE, 8'd0, 6'd6);
        deliver(8'd60);
        wait_drain("drain_60", 200);
        Empty50 = 1'b0;

        // 7c: one 5c coin then an exact-change fault
        push(K_COIN, 8'd1, 6'd0);
        push(K_FAULT, 8'd2, 6'd1);
        deliver(8'd7);
        wait_drain("drain_7", 100);
        deliver(8'd40);
        repeat (4) @(posedge CLK);
        #1;
        chk("fault_sticky", 32'(Fault), 32'd1);
        chk("fault_hold_remain", 32'(Remain), 32'd2);
        chk("fault_hold_count", 32'(CoinCount), 32'd1);
        chk("fault_noreq", 32'(EjectReq), 32'd0);
        do_reset();
        chk("fault_cleared", 32'(Fault), 32'd0);

        // 50c with no acknowledge: timeout after 8 request cycles
        ack_en = 1'b0;
        push(K_COIN, 8'd3, 6'd0);
        push(K_FAULT, 8'd50, 6'd0);
        deliver(8'd50);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK);
            #1;
            if (EjectReq) cnt++;
            if (Fault) break;
        end
        chk("timeout_req_cycles", cnt, 32'd8);
        chk("timeout_fault", 32'(Fault), 32'd1);
        chk("timeout_req_low", 32'(EjectReq), 32'd0);
        chk("timeout_remain", 32'(Remain), 32'd50);
        wait_drain("drain_timeout", 20);
        do_reset();
        ack_en = 1'b1;

        // zero change: Done after the third edge, Busy high throughout, no request
        push(K_DONE, 8'd0, 6'd0);
        deliver(8'd0);
        chk("zero_busy_t0", 32'({Busy, Done}), 32'b10);
        @(posedge CLK);
        #1;
        chk("zero_busy_t1", 32'({Busy, Done}), 32'b10);
        @(posedge CLK);
        #1;
        chk("zero_done_t2", 32'({Busy, Done}), 32'b11);
        @(posedge CLK);
        #1;
        chk("zero_idle_t3", 32'({Busy, Done}), 32'b00);
        wait_drain("drain_zero", 10);

        // Deliver edge with Enable low is ignored
        Enable = 1'b0;
        deliver(8'd40);
        repeat (3) @(posedge CLK);
        #1;
        chk("disabled_busy", 32'(Busy), 32'd0);
        chk("disabled_remain", 32'(Remain), 32'd0);
        Enable = 1'b1;

        // 100c: second edge during EJECT ignored, then async reset mid-request
        ack_en = 1'b0;
        push(K_COIN, 8'd3, 6'd0);
        deliver(8'd100);
        @(posedge CLK);
        #1;
        chk("req_100", 32'(EjectReq), 32'd1);
        Money = 8'd30;
        Deliver = 1'b1;
        @(posedge CLK);
        #1;
        Deliver = 1'b0;
        @(posedge CLK);
        #1;
        chk("ignored_edge", 32'({Busy, EjectReq, Remain, CoinCount}), 32'({1'b1, 1'b1, 8'd100, 6'd0}));
        #2;
        RST = 1'b0;
        #1;
        chk("async_reset", 32'({EjectReq, CoinSel, Busy, Done, Fault, Remain, CoinCount}), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        chk("queue_after_reset", 32'(exp_q.size()), 32'd0);
        ack_en = 1'b1;

        // fresh capture after reset
        push(K_COIN, 8'd2, 6'd0);
        push(K_COIN, 8'd1, 6'd0);
        push(K_DONE, 8'd0, 6'd2);
        deliver(8'd15);
        wait_drain("drain_15", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending machine FSM. It captures the `Money` value when `Deliver` rises and treats it as the change owed, in cents. It then pays that amount out greedily, one coin at a time, through a 4-phase request/acknowledge handshake with the coin ejector. It honours the tube-empty sensors and flags a fault when it cannot pay exactly or the ejector stops responding.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 1023: maximum number of cycles spent waiting in each handshake phase before a fault is declared; range 1..1023.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `Enable`  in  1  capture enable; gates only new captures.
- `Deliver`  in  1  deliver strobe from the vending FSM; level input, rising edge detected internally.
- `Money`  in  8  change amount in cents, unsigned binary; sampled only at capture.
- `Empty50`, `Empty10`, `Empty5`  in  1 each  coin-tube empty sensors, active-high.
- `EjectAck`  in  1  ejector acknowledge.
- `EjectReq`  out  1  ejector request.
- `CoinSel`  out  2  coin to eject: 01 = 5c, 10 = 10c, 11 = 50c, 00 = none.
- `Busy`  out  1  dispensing in progress.
- `Done`  out  1  one-cycle pulse when the change is fully paid.
- `Fault`  out  1  sticky fault flag.
- `Remain`  out  8  amount still unpaid, in cents.
- `CoinCount`  out  6  coins ejected in the current transaction.

## Operation
- **Reset values:** all outputs 0, state IDLE, registered copy of `Deliver` = 0.
- **States:** IDLE, SELECT, EJECT, RELEASE, DONE, FAULT.
- **IDLE:** a rising edge of `Deliver` (current 1, registered 0) while `Enable`=1 causes the following, then goes to SELECT:
  - `Remain` is loaded with `Money`.
  - `CoinCount` is cleared to 0.
  - `Busy` is set to 1.
- **Ignored edges:** a rising edge of `Deliver` while `Enable`=0, or in any state other than IDLE, is ignored and never queued.
- **SELECT:** evaluated in one cycle.
  - If `Remain`=0, go to DONE.
  - Otherwise pick the largest coin v in {50, 10, 5} with `Remain` >= v and its empty sensor = 0, drive `CoinSel` for that coin, assert `EjectReq`, and go to EJECT.
  - If no coin qualifies, go to FAULT.
  - Empty sensors are sampled only in SELECT.
- **EJECT:** `EjectReq`=1 and `CoinSel` are held stable. When `EjectAck` is sampled 1:
  - `Remain` is decreased by v; this never underflows because selection guarantees `Remain` >= v.
  - `CoinCount` is incremented.
  - `EjectReq` is set to 0.
  - The block goes to RELEASE.
- **RELEASE:** `EjectReq`=0 and `CoinSel` = 00. When `EjectAck` is sampled 0, go to SELECT.
- **Timeout:** a counter clears on entry to EJECT and on entry to RELEASE and increments every cycle spent in either state. When it reaches `ACK_TIMEOUT` the block goes to FAULT and drops `EjectReq` immediately.
- **DONE:**
  - `Done`=1 for exactly one cycle.
  - `Busy` is cleared.
  - Next state is IDLE.
- **FAULT:**
  - `Fault`=1, `Busy`=0, `EjectReq`=0, `CoinSel`=00.
  - `Remain` and `CoinCount` keep the values they had when the fault occurred.
  - The block stays in FAULT until `RST` is asserted; `Deliver` is ignored.
- **Amounts not divisible by 5:** the block pays down to a remainder of 1..4, then faults; `Remain` shows the unpaid cents.
- **Reset mid-transaction:** asynchronously returns the block to the reset values. Any coin whose ack had not been sampled is not counted.
- **Outputs persisting into IDLE:** `Remain` and `CoinCount` hold their final values in IDLE until the next capture.

## Timing
- **Capture:** a `Deliver` rising edge sampled at edge t loads `Remain` and sets `Busy` after t.
- **First request:** SELECT at edge t+1, so `EjectReq` is high after edge t+1.
- **Acknowledge:** `EjectAck` high sampled at edge a lowers `EjectReq` and updates `Remain` and `CoinCount` after edge a.
- **Release:** `EjectAck` low sampled at edge r puts the block in SELECT after edge r. The next `EjectReq` is high after edge r+1.
- **Done pulse:** with `Remain` reaching 0, `Done` is high in the second cycle after the final ack-low edge r (SELECT at r+1, DONE at r+2). `Busy` falls in the same cycle `Done` falls.
- **Zero change:** for `Money`=0, `Done` is high in the cycle after edge t+2, and no request is issued.
- **Throughput:** at most one coin per 4 cycles, achieved when the ejector acks within one cycle.

## Test plan
- `Money`=85, all tubes full, ejector acks 2 cycles after the request and releases 1 cycle later -> `CoinSel` sequence 11,10,10,10,01; then `Done` pulse; `Remain`=0, `CoinCount`=5, `Fault`=0.
- `Money`=60, `Empty50`=1 -> six 10c coins, `CoinCount`=6, `Done`.
- `Money`=7 -> one 5c coin, then `Fault`=1, `Remain`=2, `CoinCount`=1; a later `Deliver` edge is ignored until `RST`.
- `Money`=50, `EjectAck` held 0, `ACK_TIMEOUT`=8 -> `EjectReq` high for 8 cycles; then `Fault`=1, `EjectReq`=0, `Remain`=50.
- `Money`=0 -> `Done` pulse 3 cycles after the `Deliver` edge with `Busy` high meanwhile; no `EjectReq`; a `Deliver` edge with `Enable`=0 produces no activity.
- `Money`=100, second `Deliver` edge during EJECT -> ignored. Assert `RST` while `EjectReq`=1 -> all outputs 0 asynchronously. After release, a fresh capture works normally.
